// File: rtl/gmii_demux.sv
// rtl/gmii_demux.sv - GMII RX one-to-many frame demultiplexer with per-frame destination and statistics
module gmii_demux #(
    parameter int C_NUM_OUTPUTS = 6,
    parameter int C_SEL_WIDTH   = 8,
    parameter int C_CNT_WIDTH   = 32
) (
    input  logic                         gtx_clk,
    input  logic                         gtx_aresetn,
    input  logic [7:0]                   gmii_in_rxd,
    input  logic                         gmii_in_rx_dv,
    input  logic                         gmii_in_rx_er,
    input  logic [C_SEL_WIDTH-1:0]       select,
    input  logic                         counters_clear,
    output logic [8*C_NUM_OUTPUTS-1:0]   gmii_out_rxd,
    output logic [C_NUM_OUTPUTS-1:0]     gmii_out_rx_dv,
    output logic [C_NUM_OUTPUTS-1:0]     gmii_out_rx_er,
    output logic [C_SEL_WIDTH-1:0]       active_sel,
    output logic [C_CNT_WIDTH-1:0]       frame_cnt,
    output logic [C_CNT_WIDTH-1:0]       drop_cnt,
    output logic [C_CNT_WIDTH-1:0]       err_cnt
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    localparam logic [C_SEL_WIDTH:0]   NUM_OUT = (C_SEL_WIDTH+1)'(C_NUM_OUTPUTS);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [7:0]             rxd_r;
    logic                   dv_r;
    logic                   er_r;
    logic                   dv_prev;
    logic [C_SEL_WIDTH-1:0] sel_r;
    logic [C_SEL_WIDTH-1:0] cur;
    logic                   err_flag;

    logic                   sof;
    logic                   sel_ok;
    logic                   fwd_now;
    logic                   end_frame;
    logic                   err_now;
    logic [C_SEL_WIDTH-1:0] dest;

    assign sof       = dv_r & ~dv_prev;
    assign sel_ok    = {1'b0, sel_r} < NUM_OUT;
    assign dest      = (state == IDLE) ? sel_r : cur;
    assign fwd_now   = dv_r & (((state == IDLE) & sof & sel_ok) | (state == FWD));
    assign end_frame = ~dv_r & (state != IDLE);
    assign err_now   = dv_r & er_r & (((state == IDLE) & sof) | (state != IDLE));

    // dv_r/dv_prev come out of reset high so a frame already running at release
    // never looks like a start of frame; the FSM waits for rx_dv to drop first.
    always_ff @(posedge gtx_clk or negedge gtx_aresetn) begin
        if (!gtx_aresetn) begin
            rxd_r   <= '0;
            dv_r    <= 1'b1;
            er_r    <= 1'b0;
            sel_r   <= '0;
            dv_prev <= 1'b1;
        end else begin
            rxd_r   <= gmii_in_rxd;
            dv_r    <= gmii_in_rx_dv;
            er_r    <= gmii_in_rx_er;
            sel_r   <= select;
            dv_prev <= dv_r;
        end
    end

    always_ff @(posedge gtx_clk or negedge gtx_aresetn) begin
        if (!gtx_aresetn) begin
            state          <= IDLE;
            cur            <= '0;
            active_sel     <= '0;
            err_flag       <= 1'b0;
            gmii_out_rxd   <= '0;
            gmii_out_rx_dv <= '0;
            gmii_out_rx_er <= '0;
            frame_cnt      <= '0;
            drop_cnt       <= '0;
            err_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sof) begin
                        if (sel_ok) begin
                            state      <= FWD;
                            cur        <= sel_r;
                            active_sel <= sel_r;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                FWD:     if (!dv_r) state <= IDLE;
                DROP:    if (!dv_r) state <= IDLE;
                default: state <= IDLE;
            endcase

            for (int k = 0; k < C_NUM_OUTPUTS; k++) begin
                if (fwd_now && dest == C_SEL_WIDTH'(k)) begin
                    gmii_out_rxd[8*k +: 8] <= rxd_r;
                    gmii_out_rx_dv[k]      <= 1'b1;
                    gmii_out_rx_er[k]      <= er_r;
                end else begin
                    gmii_out_rxd[8*k +: 8] <= 8'h00;
                    gmii_out_rx_dv[k]      <= 1'b0;
                    gmii_out_rx_er[k]      <= 1'b0;
                end
            end

            err_flag <= end_frame ? 1'b0 : (err_flag | err_now);

            if (counters_clear) begin
                frame_cnt <= '0;
                drop_cnt  <= '0;
                err_cnt   <= '0;
            end else begin
                if (end_frame && state == FWD && frame_cnt != CNT_MAX)
                    frame_cnt <= frame_cnt + 1'b1;
                if (end_frame && state == DROP && drop_cnt != CNT_MAX)
                    drop_cnt <= drop_cnt + 1'b1;
                if (end_frame && err_flag && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/gmii_demux.md
Name: gmii_demux

Overview:
- Receive-side counterpart of the GMII transmit mux: one GMII RX stream in, fanned out to one of C_NUM_OUTPUTS GMII RX outputs.
- The destination is chosen per frame from the select input and frozen for the whole frame, so a frame is never split across outputs.
- Frames aimed at an invalid destination are discarded.
- Per-block saturating counters report forwarded, dropped and errored frames. Sits between the PHY/PCS RX GMII and the per-port receive engines.

Parameters:
C_NUM_OUTPUTS, 6, number of GMII outputs (1..255)
C_SEL_WIDTH, 8, width of select and active_sel
C_CNT_WIDTH, 32, width of each statistics counter

Ports:
gtx_clk  in  1  single clock; all logic on rising edge
gtx_aresetn  in  1  asynchronous active-low reset
gmii_in_rxd  in  8  GMII RX data
gmii_in_rx_dv  in  1  GMII RX data valid
gmii_in_rx_er  in  1  GMII RX error
select  in  C_SEL_WIDTH  requested destination for the next frame
counters_clear  in  1  synchronous clear of all counters
gmii_out_rxd  out  8*C_NUM_OUTPUTS  output data; port k is bits [8k+7:8k]
gmii_out_rx_dv  out  C_NUM_OUTPUTS  per-port data valid
gmii_out_rx_er  out  C_NUM_OUTPUTS  per-port error
active_sel  out  C_SEL_WIDTH  destination of the current or last frame
frame_cnt  out  C_CNT_WIDTH  frames forwarded
drop_cnt  out  C_CNT_WIDTH  frames dropped (invalid select)
err_cnt  out  C_CNT_WIDTH  frames with rx_er during rx_dv

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0, state IDLE, all counters 0;
  - dv_prev resets to 1, so a frame already in progress when reset releases is not forwarded (the FSM waits for rx_dv low).
- Stage 1: gmii_in_* and select are registered every cycle (rxd_r, dv_r, er_r, sel_r); dv_prev <= dv_r.
- Stage 2: output registers. Latency is exactly 2 cycles from input to the selected output, including the first byte.
- SOF = dv_r & ~dv_prev.
- FSM states IDLE, FWD, DROP, evaluated on stage-1 values:
  - IDLE, on SOF:
    - sel_r < C_NUM_OUTPUTS: go to FWD, latch cur = sel_r, active_sel <= sel_r, forward this byte;
    - otherwise: go to DROP; active_sel is unchanged.
  - IDLE, otherwise: stay; nothing is forwarded.
  - FWD, dv_r=1: port cur gets rxd_r, dv=1, er=er_r; every other port gets 0.
  - FWD, dv_r=0: return to IDLE, frame_cnt += 1, and the port cur outputs go to 0 (dv=0, er=0, rxd=0).
  - DROP, dv_r=1: stay; nothing is output.
  - DROP, dv_r=0: return to IDLE, drop_cnt += 1.
- SOF on the cycle after the frame-ending idle cycle is accepted, so a 1-cycle inter-frame gap is supported.
- Changes on select during FWD or DROP are ignored; only the sel_r value at SOF matters.
- rx_er with rx_dv=0 (false carrier, carrier extension) is never forwarded and never counted.
- Non-selected ports hold rxd=0, dv=0, er=0 at all times.
- Error flag:
  - set on any cycle with dv_r & er_r in FWD or DROP (including the SOF cycle);
  - at end of frame, err_cnt += 1 once if the flag is set, then the flag clears;
  - an errored frame also increments frame_cnt or drop_cnt as appropriate.
- Counters:
  - saturate at all-ones (no wrap);
  - counters_clear=1 forces all three to 0 on the next edge and takes priority over a simultaneous increment;
  - the flag of an in-progress frame is not affected by counters_clear.
- Assertion of gtx_aresetn mid-frame zeroes all outputs immediately; the remainder of that frame is not forwarded.

Test Plan:
- select=2, 64-byte frame (0x55 x7, 0xD5, payload 0x00..0x37) -> port 2 reproduces every byte exactly 2 cycles later; ports 0,1,3,4,5 stay 0; active_sel=2; frame_cnt=1.
- select=2 at SOF, changed to 4 at byte 20; 1-cycle gap; second frame -> frame 1 wholly on port 2, frame 2 wholly on port 4; frame_cnt=2.
- select=7 (C_NUM_OUTPUTS=6), 60-byte frame -> no output dv on any port; drop_cnt=1; active_sel keeps its prior value.
- select=1, rx_er high on byte 10 only; then rx_er=1 with rx_dv=0 for 5 cycles -> port 1 er pulses 2 cycles after byte 10; err_cnt=1; the false carrier produces no output and no count.
- Reset asserted at byte 30 of a 100-byte frame, released at byte 40 -> outputs 0 from reset assertion to frame end; next frame forwarded normally; counters 0 then 1.
- Force frame_cnt to all-ones via 2^C_CNT_WIDTH-1 frames (reduced C_CNT_WIDTH=4 build: 15 frames) then 1 more -> stays 15. Pulse counters_clear on the end-of-frame cycle -> frame_cnt=0.
